// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// parity control bit positions and stop-bit count encoding.
// The BREAK and MARK states are compiled in only with UART_TX_BREAK_EN.
package uart_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
    localparam logic [2:0] S_MARK   = 3'd6;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
`ifdef UART_TX_BREAK_EN
        ,
        ST_BREAK  = S_BREAK,
        ST_MARK   = S_MARK
`endif
    } uart_state_t;

    // Bit positions inside the 2-bit parity control word
    localparam int PAR_EN  = 1;
    localparam int PAR_ODD = 0;

    // Stop-bit count encoding: number of stop bits = code + 1
    localparam logic [1:0] STOP_1 = 2'd0;
    localparam logic [1:0] STOP_2 = 2'd1;
    localparam logic [1:0] STOP_3 = 2'd2;
    localparam logic [1:0] STOP_4 = 2'd3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO for the UART transmit path. Pointers carry one extra
// MSB so full and empty are told apart by the wrap bit. Read data is the
// word at the head, valid whenever the FIFO is not empty.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Read/write pointers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign o_rdata = mem[rd_ptr[AW-1:0]];
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: valid/ready write port into a FIFO, frame FSM
// with baud counter, bit counter, parity and a registered TXD output.
// Frames are sent back to back while the FIFO holds data.
// Optional feature macro: UART_TX_BREAK_EN adds i_break and BREAK/MARK states.
//
// Write handshake: a word is accepted on any rising clock edge where
// i_tx_valid and o_tx_ready are both high; o_tx_ready depends only on FIFO
// fullness, never on i_tx_valid.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [DIV_W-1:0]              i_div,
    input  logic [1:0]                    i_parity,
    input  logic [1:0]                    i_stop,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    input  logic [DATA_W-1:0]             i_tx_data,
    output logic                          o_uart_txd,
    output logic                          o_busy,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
`ifdef UART_TX_BREAK_EN
    input  logic                          i_break,
`endif
    output logic [2:0]                    o_fsm_state
);
    localparam int BIT_W = $clog2(DATA_W + 1);

    uart_state_t        state_q, state_n;
    logic [DIV_W-1:0]   cnt_q, cnt_n;
    logic [BIT_W-1:0]   bit_q, bit_n;
    logic [DATA_W-1:0]  shift_q, shift_n;
    logic               txd_q, txd_n;
    logic [DIV_W-1:0]   div_l;
    logic               par_en_l;
    logic               par_q;
    logic [1:0]         stop_l;
    logic               bit_end;
    logic               pop;
    logic               done;
    logic               div_latch;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_rdata;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (i_tx_valid),
        .i_wdata   (i_tx_data),
        .i_pop     (pop),
        .o_rdata   (fifo_rdata),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (o_fifo_level)
    );

    assign bit_end = (cnt_q == div_l);

    // Next-state, counters and next TXD value
    always_comb begin
        state_n   = state_q;
        cnt_n     = bit_end ? '0 : cnt_q + 1'b1;
        bit_n     = bit_q;
        shift_n   = shift_q;
        pop       = 1'b0;
        done      = 1'b0;
        div_latch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
`ifdef UART_TX_BREAK_EN
                if (i_break) begin
                    state_n   = ST_BREAK;
                    div_latch = 1'b1;
                end else
`endif
                if (!fifo_empty) begin
                    state_n = ST_START;
                    pop     = 1'b1;
                    bit_n   = '0;
                    shift_n = fifo_rdata;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_n = par_en_l ? ST_PARITY : ST_STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shift_n = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    bit_n   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(stop_l)) begin
                        done  = 1'b1;
                        bit_n = '0;
`ifdef UART_TX_BREAK_EN
                        if (i_break) begin
                            state_n   = ST_BREAK;
                            div_latch = 1'b1;
                        end else
`endif
                        if (!fifo_empty) begin
                            state_n = ST_START;
                            pop     = 1'b1;
                            shift_n = fifo_rdata;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                cnt_n = '0;
                if (!i_break) begin
                    state_n = ST_MARK;
                end
            end
            ST_MARK: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        state_n = ST_START;
                        pop     = 1'b1;
                        bit_n   = '0;
                        shift_n = fifo_rdata;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        case (state_n)
            ST_START:  txd_n = 1'b0;
            ST_DATA:   txd_n = shift_n[0];
            ST_PARITY: txd_n = par_q;
`ifdef UART_TX_BREAK_EN
            ST_BREAK:  txd_n = 1'b0;
`endif
            default:   txd_n = 1'b1;
        endcase
    end

    // FSM state, counters, shift register and TXD register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            txd_q   <= txd_n;
        end
    end

    // Per-frame configuration, captured when a word is popped
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_l    <= '0;
            par_en_l <= 1'b0;
            par_q    <= 1'b0;
            stop_l   <= STOP_1;
        end else if (pop) begin
            div_l    <= i_div;
            par_en_l <= i_parity[PAR_EN];
            par_q    <= (^fifo_rdata) ^ i_parity[PAR_ODD];
            stop_l   <= i_stop;
        end else if (div_latch) begin
            div_l    <= i_div;
        end
    end

    assign o_uart_txd  = txd_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_tx_done   = done;
    assign o_tx_ready  = !fifo_full;
    assign o_fsm_state = state_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Testbench for uart_tx_buf: an 8-bit instance and a 5-bit instance, both
// with a 4-entry FIFO. Expected TXD waveforms are built per pushed word and
// compared clock by clock as frames appear on the line.
module tb_uart_tx_buf;

    localparam int FW = 128;

    typedef struct {
        logic [FW-1:0] bits;
        int            len;
    } frame_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [15:0] div8,  div5;
    logic [1:0]  par8,  par5;
    logic [1:0]  stop8, stop5;
    logic        valid8, valid5;
    logic        ready8, ready5;
    logic [7:0]  data8;
    logic [4:0]  data5;
    logic        txd8, txd5;
    logic        busy8, busy5;
    logic        done8, done5;
    logic [2:0]  level8, level5;
    logic [2:0]  state8, state5;
    logic        break8, break5;

    uart_tx_buf #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) u_dut8 (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_div        (div8),
        .i_parity     (par8),
        .i_stop       (stop8),
        .i_tx_valid   (valid8),
        .o_tx_ready   (ready8),
        .i_tx_data    (data8),
        .o_uart_txd   (txd8),
        .o_busy       (busy8),
        .o_tx_done    (done8),
        .o_fifo_level (level8),
`ifdef UART_TX_BREAK_EN
        .i_break      (break8),
`endif
        .o_fsm_state  (state8)
    );

    uart_tx_buf #(.DATA_W(5), .DIV_W(16), .FIFO_DEPTH(4)) u_dut5 (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_div        (div5),
        .i_parity     (par5),
        .i_stop       (stop5),
        .i_tx_valid   (valid5),
        .o_tx_ready   (ready5),
        .i_tx_data    (data5),
        .o_uart_txd   (txd5),
        .o_busy       (busy5),
        .o_tx_done    (done5),
        .o_fifo_level (level5),
`ifdef UART_TX_BREAK_EN
        .i_break      (break5),
`endif
        .o_fsm_state  (state5)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    frame_t exp_q0[$];
    frame_t exp_q1[$];

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t make_frame(input int dw, input logic [8:0] d, input int div,
                                          input logic [1:0] par, input logic [1:0] stop);
        frame_t f;
        logic   seq [16];
        int     n;
        int     ones;
        int     pos;
        f.bits = '0;
        n = 0;
        ones = 0;
        seq[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < dw; i++) begin
            seq[n] = d[i];
            if (d[i]) ones = ones + 1;
            n = n + 1;
        end
        if (par[1]) begin
            seq[n] = ((ones % 2) == 1) ^ par[0];
            n = n + 1;
        end
        for (int s = 0; s <= int'(stop); s++) begin
            seq[n] = 1'b1;
            n = n + 1;
        end
        pos = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k <= div; k++) begin
                f.bits[pos] = seq[i];
                pos = pos + 1;
            end
        end
        f.len = pos;
        return f;
    endfunction

    // ---------------- line monitor ----------------
    bit            mon_en       [2];
    bit            in_frame     [2];
    int            idx          [2];
    frame_t        cur          [2];
    logic [FW-1:0] cap_t        [2];
    logic [FW-1:0] cap_d        [2];
    int            frames_done  [2];
    int            last_end     [2];
    int            burst_frames [2];
    int            burst_gap    [2];

    task automatic mon_step(input int id, input logic txd, input logic done);
        logic [FW-1:0] exp_done;
        if (!mon_en[id]) return;
        if (!in_frame[id]) begin
            if (txd === 1'b0) begin
                if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                    check($sformatf("unexpected_start%0d", id), 1, 0);
                    mon_en[id] = 1'b0;
                    return;
                end
                cur[id] = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                in_frame[id] = 1'b1;
                idx[id] = 0;
                cap_t[id] = '0;
                cap_d[id] = '0;
                if (burst_frames[id] > 0) burst_gap[id] += cyc - last_end[id] - 1;
            end else if (done !== 1'b0) begin
                check($sformatf("stray_done%0d", id), done, 0);
            end
        end
        if (in_frame[id]) begin
            cap_t[id][idx[id]] = txd;
            cap_d[id][idx[id]] = done;
            idx[id] = idx[id] + 1;
            if (idx[id] == cur[id].len) begin
                exp_done = '0;
                exp_done[cur[id].len - 1] = 1'b1;
                check($sformatf("frame_txd%0d", id), cap_t[id], cur[id].bits);
                check($sformatf("frame_done%0d", id), cap_d[id], exp_done);
                in_frame[id] = 1'b0;
                last_end[id] = cyc;
                burst_frames[id]++;
                frames_done[id]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, txd8, done8);
        mon_step(1, txd5, done5);
    end

    // ---------------- driver tasks ----------------
    task automatic push(input int id, input logic [8:0] d, output bit acc);
        @(negedge clk);
        if (id == 0) begin
            valid8 = 1'b1;
            data8  = d[7:0];
            acc    = ready8;
            if (acc) exp_q0.push_back(make_frame(8, d, int'(div8), par8, stop8));
        end else begin
            valid5 = 1'b1;
            data5  = d[4:0];
            acc    = ready5;
            if (acc) exp_q1.push_back(make_frame(5, d, int'(div5), par5, stop5));
        end
        @(posedge clk);
    endtask

    task automatic release_valid();
        @(negedge clk);
        valid8 = 1'b0;
        valid5 = 1'b0;
    endtask

    task automatic push_one(input int id, input logic [8:0] d);
        bit acc;
        push(id, d, acc);
        check($sformatf("accept%0d", id), acc, 1);
        release_valid();
    endtask

    task automatic wait_idle(input int id);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (id == 0) ok = (exp_q0.size() == 0) && !in_frame[0] && !busy8;
            else         ok = (exp_q1.size() == 0) && !in_frame[1] && !busy5;
        end
        check($sformatf("idle_timeout%0d", id), ok, 1);
    endtask

    task automatic clear_burst(input int id);
        burst_frames[id] = 0;
        burst_gap[id]    = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        bit ok;
        int cnt;

        rst_n  = 1'b0;
        div8 = 16'd3;  par8 = 2'b00; stop8 = 2'b00; valid8 = 1'b0; data8 = '0; break8 = 1'b0;
        div5 = 16'd0;  par5 = 2'b00; stop5 = 2'b00; valid5 = 1'b0; data5 = '0; break5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mon_en[i] = 1'b1; in_frame[i] = 1'b0; idx[i] = 0; frames_done[i] = 0;
            last_end[i] = 0; burst_frames[i] = 0; burst_gap[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd8, 1);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_level", level8, 0);
        check("rst_ready", ready8, 1);
        check("rst_txd5", txd5, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, 4 clocks per bit, 0x55; also checks handshake-to-start latency
        div8 = 16'd3; par8 = 2'b00; stop8 = 2'b00;
        push(0, 9'h055, acc);
        check("t1_accept", acc, 1);
        #1;
        check("lat_txd_pre", txd8, 1);
        check("lat_busy_pre", busy8, 0);
        valid8 = 1'b0;
        @(posedge clk);
        #1;
        check("lat_txd_start", txd8, 0);
        check("lat_busy_start", busy8, 1);
        wait_idle(0);

        // Parity even / odd on 0x07, then four stop bits
        div8 = 16'd1; par8 = 2'b10; stop8 = 2'b00;
        push_one(0, 9'h007);
        wait_idle(0);
        par8 = 2'b11;
        push_one(0, 9'h007);
        wait_idle(0);
        par8 = 2'b00; stop8 = 2'b11;
        push_one(0, 9'h0A3);
        wait_idle(0);

        // FIFO fill: 6 pushes on consecutive clocks, 5 accepted, back-to-back frames
        div8 = 16'd9; par8 = 2'b00; stop8 = 2'b00;
        clear_burst(0);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(0, 9'($urandom_range(0, 255)), acc);
            if (acc) n_acc++;
        end
        #1;
        check("fill_level", level8, 4);
        check("fill_ready", ready8, 0);
        check("fill_accepted", n_acc, 5);
        release_valid();
        wait_idle(0);
        check("fill_frames", burst_frames[0], 5);
        check("fill_gap", burst_gap[0], 0);

        // 5-bit instance, 1 clock per bit, even parity: two 8-clock frames, no gap
        div5 = 16'd0; par5 = 2'b10; stop5 = 2'b00;
        clear_burst(1);
        push(1, 9'h01F, acc);
        check("b2b_acc0", acc, 1);
        push(1, 9'h000, acc);
        check("b2b_acc1", acc, 1);
        release_valid();
        wait_idle(1);
        check("b2b_frames", burst_frames[1], 2);
        check("b2b_gap", burst_gap[1], 0);

        // Random configurations on both instances
        for (int r = 0; r < 4; r++) begin
            div8 = 16'($urandom_range(0, 3)); par8 = 2'($urandom_range(0, 3)); stop8 = 2'($urandom_range(0, 3));
            push_one(0, 9'($urandom_range(0, 255)));
            wait_idle(0);
            div5 = 16'($urandom_range(0, 3)); par5 = 2'($urandom_range(0, 3)); stop5 = 2'($urandom_range(0, 3));
            push_one(1, 9'($urandom_range(0, 31)));
            wait_idle(1);
        end

        // Reset in the middle of data bit 3 with two words queued
        div8 = 16'd3; par8 = 2'b00; stop8 = 2'b00;
        for (int i = 0; i < 3; i++) push(0, 9'($urandom_range(0, 255)), acc);
        release_valid();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = in_frame[0] && (idx[0] >= 18);
        end
        check("rst_mid_reach", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_txd", txd8, 1);
        check("rst_mid_level", level8, 0);
        check("rst_mid_busy", busy8, 0);
        check("rst_mid_ready", ready8, 1);
        exp_q0.delete();
        in_frame[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_one(0, 9'h03C);
        wait_idle(0);

`ifdef UART_TX_BREAK_EN
        // Break raised mid-frame: frame completes, line held low, then one mark bit
        div8 = 16'd2; par8 = 2'b00; stop8 = 2'b00;
        push_one(0, 9'h0C5);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = in_frame[0];
        end
        check("brk_frame_start", ok, 1);
        break8 = 1'b1;
        push_one(0, 9'h05A);
        cnt = frames_done[0];
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (frames_done[0] != cnt);
        end
        check("brk_frame_end", ok, 1);
        mon_en[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (txd8 == 1'b0) cnt++;
            @(posedge clk);
            #1;
        end
        check("brk_low_clocks", cnt, 10);
        check("brk_busy", busy8, 1);
        check("brk_level", level8, 1);
        @(negedge clk);
        break8 = 1'b0;
        cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (txd8 == 1'b1) cnt++;
            else ok = 1'b1;
        end
        check("mark_clocks", cnt, 3);
        mon_en[0] = 1'b1;
        wait_idle(0);
`endif

        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
